// File: rtl/mux_n_pipe.sv
// Registered N-way lane selector feeding a 2-entry elastic buffer (head + skid)
// with valid/ready on both sides and per-entry out-of-range select flag.
module mux_n_pipe #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned N     = 4,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic [SEL_W-1:0]   SEL,
  input  logic [N*WIDTH-1:0] Dato,
  input  logic               In_Valid,
  output logic               In_Ready,
  input  logic               Flush,
  output logic [WIDTH-1:0]   Out_Mux,
  output logic               Out_Valid,
  input  logic               Out_Ready,
  output logic               Sel_Err,
  output logic [1:0]         Occupancy
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_head;
  logic             r_head_err;
  logic [WIDTH-1:0] r_skid;
  logic             r_skid_err;
  logic             r_out_valid;
  logic             r_in_ready;

  logic [1:0]       w_nxt_state;
  logic [WIDTH-1:0] w_nxt_head;
  logic             w_nxt_head_err;
  logic [WIDTH-1:0] w_nxt_skid;
  logic             w_nxt_skid_err;
  logic             w_accept;
  logic             w_pop;
  logic [WIDTH-1:0] w_new_data;
  logic             w_new_err;

  assign w_accept = In_Valid & r_in_ready;
  assign w_pop    = r_out_valid & Out_Ready;

  // Lane decode; a select with no matching lane yields zero data and err=1.
  always_comb begin
    w_new_data = '0;
    w_new_err  = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (SEL == SEL_W'(k)) begin
        w_new_data = Dato[k*WIDTH +: WIDTH];
        w_new_err  = 1'b0;
      end
    end
  end

  // State and storage register
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state     <= ST_EMPTY;
      r_head      <= '0;
      r_head_err  <= 1'b0;
      r_skid      <= '0;
      r_skid_err  <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_nxt_state;
      r_head      <= w_nxt_head;
      r_head_err  <= w_nxt_head_err;
      r_skid      <= w_nxt_skid;
      r_skid_err  <= w_nxt_skid_err;
      r_out_valid <= (w_nxt_state != ST_EMPTY);
      r_in_ready  <= (w_nxt_state != ST_FULL);
    end
  end

  // Next-state / storage update; Flush overrides any accept or pop.
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_head     = r_head;
    w_nxt_head_err = r_head_err;
    w_nxt_skid     = r_skid;
    w_nxt_skid_err = r_skid_err;
    if (Flush) begin
      w_nxt_state = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_nxt_state    = ST_ONE;
            w_nxt_head     = w_new_data;
            w_nxt_head_err = w_new_err;
          end
        end
        ST_ONE: begin
          if (w_accept && !w_pop) begin
            w_nxt_state    = ST_FULL;
            w_nxt_skid     = w_new_data;
            w_nxt_skid_err = w_new_err;
          end else if (w_accept && w_pop) begin
            w_nxt_head     = w_new_data;
            w_nxt_head_err = w_new_err;
          end else if (w_pop) begin
            w_nxt_state = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            w_nxt_state    = ST_ONE;
            w_nxt_head     = r_skid;
            w_nxt_head_err = r_skid_err;
          end
        end
        default: w_nxt_state = ST_EMPTY;
      endcase
    end
  end

  assign Out_Mux   = r_head;
  assign Sel_Err   = r_head_err;
  assign Out_Valid = r_out_valid;
  assign In_Ready  = r_in_ready;
  assign Occupancy = r_state;

endmodule
